vx_muldiv_sequencer: RTL and testbench

Front-end controller for the shared muldiv execute unit. It accepts one full-warp request (NUM_THREADS lanes) and issues it as a sequence of NUM_LANES-wide packets carrying pid/sop/eop, as the muldiv unit expects. Lane batches whose thread mask slice is all-zero are skipped. It sits between the dispatch stage and the muldiv unit's execute interface.

---
 rtl/vx_muldiv_sequencer_pkg.sv | 21 ++
 rtl/vx_muldiv_sequencer_findnext.sv | 34 +++
 rtl/vx_muldiv_sequencer.sv | 122 ++++++++++++
 tb/tb_vx_muldiv_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vx_muldiv_sequencer_pkg.sv
// Shared constants and FSM encoding for the muldiv front-end sequencer.
package vx_muldiv_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } seq_state_e;

    function automatic int unsigned up1(input int unsigned x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic int unsigned num_pkts(input int unsigned threads, input int unsigned lanes);
        return threads / lanes;
    endfunction

    function automatic int unsigned pid_width(input int unsigned threads, input int unsigned lanes);
        return up1($clog2(threads / lanes));
    endfunction

endpackage

// File: rtl/vx_muldiv_sequencer_findnext.sv
// Finds the lowest set bit of i_vec at/above i_base and reports whether any set bit lies beyond it.
module vx_muldiv_sequencer_findnext #(
    parameter int unsigned N         = 4,
    parameter int unsigned PID_WIDTH = 2,
    parameter bit          INCLUSIVE = 1'b0
) (
    input  logic [N-1:0]         i_vec,
    input  logic [PID_WIDTH-1:0] i_base,
    output logic [PID_WIDTH-1:0] o_idx,
    output logic                 o_has_next
);

    logic [N:0]   w_lo;
    logic [N:0]   w_hi;
    logic [N-1:0] w_masked;
    logic         w_found;

    // One extra bit on the masks so a shift by N still yields an all-ones mask.
    always_comb begin
        w_lo     = ((N+1)'(1) << (32'(i_base) + (INCLUSIVE ? 32'd0 : 32'd1))) - (N+1)'(1);
        w_masked = i_vec & ~w_lo[N-1:0];
        o_idx    = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_masked[i] && !w_found) begin
                o_idx   = PID_WIDTH'(i);
                w_found = 1'b1;
            end
        end
        w_hi       = ((N+1)'(1) << (32'(o_idx) + 32'd1)) - (N+1)'(1);
        o_has_next = |(w_masked & ~w_hi[N-1:0]);
    end

endmodule

// File: rtl/vx_muldiv_sequencer.sv
// Splits one warp-wide muldiv request into NUM_LANES-wide packets, skipping all-zero lane batches.
module vx_muldiv_sequencer
    import vx_muldiv_sequencer_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TAG_WIDTH   = 64,
    localparam int unsigned NUM_PKTS   = num_pkts(NUM_THREADS, NUM_LANES),
    localparam int unsigned PID_WIDTH  = pid_width(NUM_THREADS, NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic [TAG_WIDTH-1:0]        tag_in,
    input  logic [NUM_THREADS-1:0]      tmask_in,
    input  logic [NUM_THREADS*XLEN-1:0] rs1_in,
    input  logic [NUM_THREADS*XLEN-1:0] rs2_in,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic [TAG_WIDTH-1:0]        tag_out,
    output logic [NUM_LANES-1:0]        tmask_out,
    output logic [NUM_LANES*XLEN-1:0]   rs1_out,
    output logic [NUM_LANES*XLEN-1:0]   rs2_out,
    output logic [PID_WIDTH-1:0]        pid_out,
    output logic                        sop_out,
    output logic                        eop_out
);

    if (NUM_THREADS % NUM_LANES != 0) begin : g_bad_cfg
        $error("NUM_THREADS must be a multiple of NUM_LANES");
    end

    seq_state_e                  r_state, w_state_nxt;
    logic [TAG_WIDTH-1:0]        r_tag;
    logic [NUM_THREADS-1:0]      r_tmask;
    logic [NUM_THREADS*XLEN-1:0] r_rs1, r_rs2;
    logic [NUM_PKTS-1:0]         r_bm, w_bm_in;
    logic [PID_WIDTH-1:0]        r_pid, w_cap_idx, w_nxt_idx;
    logic                        r_sop, r_eop, w_cap_has_next, w_nxt_has_next;
    logic                        w_fire_in, w_fire_out;

    always_comb begin
        w_bm_in = '0;
        for (int unsigned k = 0; k < NUM_PKTS; k++) begin
            w_bm_in[k] = |tmask_in[k*NUM_LANES +: NUM_LANES];
        end
    end

    vx_muldiv_sequencer_findnext #(
        .N(NUM_PKTS), .PID_WIDTH(PID_WIDTH), .INCLUSIVE(1'b1)
    ) u_find_first (
        .i_vec(w_bm_in), .i_base('0), .o_idx(w_cap_idx), .o_has_next(w_cap_has_next)
    );

    vx_muldiv_sequencer_findnext #(
        .N(NUM_PKTS), .PID_WIDTH(PID_WIDTH), .INCLUSIVE(1'b0)
    ) u_find_next (
        .i_vec(r_bm), .i_base(r_pid), .o_idx(w_nxt_idx), .o_has_next(w_nxt_has_next)
    );

    assign w_fire_in  = valid_in && ready_in;
    assign w_fire_out = (r_state == BUSY) && ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fire_in) w_state_nxt = BUSY;
            BUSY:    if (w_fire_out && r_eop) w_state_nxt = w_fire_in ? BUSY : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_out = (r_state == BUSY);
        ready_in  = (r_state == IDLE) || ((r_state == BUSY) && ready_out && r_eop);
    end

    // A capture takes priority: it only coincides with an output fire on the eop packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pid <= '0;
            r_sop <= 1'b0;
            r_eop <= 1'b0;
        end else if (w_fire_in) begin
            r_pid <= w_cap_idx;
            r_sop <= 1'b1;
            r_eop <= ~w_cap_has_next;
        end else if (w_fire_out && !r_eop) begin
            r_pid <= w_nxt_idx;
            r_sop <= 1'b0;
            r_eop <= ~w_nxt_has_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire_in) begin
            r_tag   <= tag_in;
            r_tmask <= tmask_in;
            r_rs1   <= rs1_in;
            r_rs2   <= rs2_in;
            r_bm    <= w_bm_in;
        end
    end

    assign tag_out   = r_tag;
    assign tmask_out = r_tmask[32'(r_pid)*NUM_LANES +: NUM_LANES];
    assign rs1_out   = r_rs1[32'(r_pid)*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign rs2_out   = r_rs2[32'(r_pid)*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign pid_out   = r_pid;
    assign sop_out   = r_sop;
    assign eop_out   = r_eop;

    a_valid_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(valid_out));

endmodule

// File: tb/tb_vx_muldiv_sequencer.sv
// Directed self-checking bench for vx_muldiv_sequencer (8 threads, 2 lanes).
module tb_vx_muldiv_sequencer;

    localparam int unsigned NT = 8;
    localparam int unsigned NL = 2;
    localparam int unsigned XL = 32;
    localparam int unsigned TW = 64;

    logic           clk, reset;
    logic           valid_in, ready_in, valid_out, ready_out;
    logic [TW-1:0]  tag_in, tag_out;
    logic [NT-1:0]  tmask_in;
    logic [NL-1:0]  tmask_out;
    logic [NT*XL-1:0] rs1_in, rs2_in;
    logic [NL*XL-1:0] rs1_out, rs2_out;
    logic [1:0]     pid_out;
    logic           sop_out, eop_out;

    int n_tests = 0;
    int n_fail  = 0;

    vx_muldiv_sequencer #(
        .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_in(ready_in),
        .tag_in(tag_in), .tmask_in(tmask_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .valid_out(valid_out), .ready_out(ready_out),
        .tag_out(tag_out), .tmask_out(tmask_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .pid_out(pid_out), .sop_out(sop_out), .eop_out(eop_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_rs1(input int p);
        return {32'(2*p+1), 32'(2*p)};
    endfunction

    function automatic logic [63:0] exp_rs2(input int p);
        return {32'(32'h100 + 2*p + 1), 32'(32'h100 + 2*p)};
    endfunction

    task automatic pkt(input string tag, input int p, input logic [1:0] tm, input logic s, input logic e);
        check({tag, ".valid"}, 64'(valid_out), 64'(1'b1));
        check({tag, ".pid"},   64'(pid_out),   64'(p));
        check({tag, ".tmask"}, 64'(tmask_out), 64'(tm));
        check({tag, ".sop"},   64'(sop_out),   64'(s));
        check({tag, ".eop"},   64'(eop_out),   64'(e));
        check({tag, ".rs1"},   rs1_out,        exp_rs1(p));
        check({tag, ".rs2"},   rs2_out,        exp_rs2(p));
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
        tag_in = '0; tmask_in = '0;
        for (int t = 0; t < int'(NT); t++) begin
            rs1_in[t*XL +: XL] = 32'(t);
            rs2_in[t*XL +: XL] = 32'(32'h100 + t);
        end
        tick(); tick();
        reset = 1'b0;
        check("rst.valid", 64'(valid_out), 64'd0);
        check("rst.ready", 64'(ready_in),  64'd1);
        check("rst.pid",   64'(pid_out),   64'd0);
        check("rst.sop",   64'(sop_out),   64'd0);
        check("rst.eop",   64'(eop_out),   64'd0);

        // 1: full mask, 4 packets back to back
        valid_in = 1'b1; tmask_in = 8'hFF; tag_in = 64'hA1A1_0000_1234_5678; ready_out = 1'b1;
        check("t1.ready_in", 64'(ready_in), 64'd1);
        check("t1.pre_valid", 64'(valid_out), 64'd0);
        tick(); valid_in = 1'b0;
        pkt("t1.p0", 0, 2'b11, 1'b1, 1'b0);
        check("t1.tag0", tag_out, 64'hA1A1_0000_1234_5678);
        for (int p = 1; p < 4; p++) begin
            tick();
            pkt("t1.pn", p, 2'b11, 1'b0, p == 3);
        end
        check("t1.tag3", tag_out, 64'hA1A1_0000_1234_5678);
        check("t1.ready_eop", 64'(ready_in), 64'd1);
        tick();
        check("t1.idle", 64'(valid_out), 64'd0);

        // 2: single middle batch
        valid_in = 1'b1; tmask_in = 8'h30;
        tick(); valid_in = 1'b0;
        pkt("t2.p2", 2, 2'b11, 1'b1, 1'b1);
        tick();
        check("t2.idle", 64'(valid_out), 64'd0);
        check("t2.ready", 64'(ready_in), 64'd1);

        // 3: sparse mask skips pid1/pid2
        valid_in = 1'b1; tmask_in = 8'h81;
        tick(); valid_in = 1'b0;
        pkt("t3.p0", 0, 2'b01, 1'b1, 1'b0);
        tick();
        pkt("t3.p3", 3, 2'b10, 1'b0, 1'b1);
        tick();
        check("t3.idle", 64'(valid_out), 64'd0);

        // 4: backpressure at pid1
        valid_in = 1'b1; tmask_in = 8'hFF;
        tick(); valid_in = 1'b0;
        pkt("t4.p0", 0, 2'b11, 1'b1, 1'b0);
        tick();
        ready_out = 1'b0;
        pkt("t4.p1", 1, 2'b11, 1'b0, 1'b0);
        check("t4.ready_in_busy", 64'(ready_in), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            pkt("t4.hold", 1, 2'b11, 1'b0, 1'b0);
        end
        ready_out = 1'b1;
        tick();
        pkt("t4.p2", 2, 2'b11, 1'b0, 1'b0);
        tick();
        pkt("t4.p3", 3, 2'b11, 1'b0, 1'b1);
        tick();
        check("t4.idle", 64'(valid_out), 64'd0);

        // 5: back-to-back A (0x0C) then B (0x03), no bubble
        valid_in = 1'b1; tmask_in = 8'h0C; tag_in = 64'h0000_0000_0000_00AA;
        tick();
        tmask_in = 8'h03; tag_in = 64'h0000_0000_0000_00BB;
        pkt("t5.A", 1, 2'b11, 1'b1, 1'b1);
        check("t5.tagA", tag_out, 64'h0000_0000_0000_00AA);
        check("t5.ready_in", 64'(ready_in), 64'd1);
        tick(); valid_in = 1'b0;
        pkt("t5.B", 0, 2'b11, 1'b1, 1'b1);
        check("t5.tagB", tag_out, 64'h0000_0000_0000_00BB);
        tick();
        check("t5.idle", 64'(valid_out), 64'd0);

        // 6: async reset mid-sequence, then recovery and empty mask
        valid_in = 1'b1; tmask_in = 8'hFF;
        tick(); valid_in = 1'b0;
        tick();
        ready_out = 1'b0;
        pkt("t6.p1", 1, 2'b11, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("t6.rst_valid", 64'(valid_out), 64'd0);
        check("t6.rst_pid",   64'(pid_out),   64'd0);
        check("t6.rst_sop",   64'(sop_out),   64'd0);
        check("t6.rst_ready", 64'(ready_in),  64'd1);
        tick();
        reset = 1'b0;
        check("t6.post_ready", 64'(ready_in), 64'd1);
        check("t6.post_valid", 64'(valid_out), 64'd0);
        valid_in = 1'b1; tmask_in = 8'h01; ready_out = 1'b1;
        tick(); valid_in = 1'b0;
        pkt("t6.new", 0, 2'b01, 1'b1, 1'b1);
        tick();
        check("t6.idle", 64'(valid_out), 64'd0);
        valid_in = 1'b1; tmask_in = 8'h00;
        tick(); valid_in = 1'b0;
        pkt("t6.empty", 0, 2'b00, 1'b1, 1'b1);
        tick();
        check("t6.idle2", 64'(valid_out), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
